// File: rtl/encoder_pkg.sv
// Shared widths and reset value for the 8-to-3 priority encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package encoder_pkg;
  localparam int IN_W  = 8;
  localparam int OUT_W = 3;
  localparam logic [OUT_W-1:0] IDX_RST = 3'b000;
endpackage

// File: rtl/encoder_8to3_core.sv
// Combinational 8-to-3 priority encoder; bit 7 has the highest priority.
// Latency: zero (purely combinational).
// Backpressure: none; the output follows the input vector.
module encoder_8to3_core
  import encoder_pkg::*;
(
  input  logic [IN_W-1:0]  i_vec,
  output logic [OUT_W-1:0] o_idx,
  output logic             o_nz,
  output logic             o_multi
);

  // Highest-bit-first priority chain; an all-zero vector yields the reset index.
  always_comb begin
    o_idx = IDX_RST;
    casez (i_vec)
      8'b1???????: o_idx = 3'd7;
      8'b01??????: o_idx = 3'd6;
      8'b001?????: o_idx = 3'd5;
      8'b0001????: o_idx = 3'd4;
      8'b00001???: o_idx = 3'd3;
      8'b000001??: o_idx = 3'd2;
      8'b0000001?: o_idx = 3'd1;
      default:     o_idx = IDX_RST;
    endcase
  end

  assign o_nz = |i_vec;

  // Clearing the lowest set bit leaves something behind only if two or more bits were set.
  assign o_multi = |(i_vec & (i_vec - IN_W'(1)));

endmodule

// File: rtl/encoder_8to3.sv
// Registered 8-to-3 priority encoder with enable, valid and multiple-request flags.
// Latency: one cycle from sampling edge to outputs.
// Backpressure: none; a new result every cycle, no handshake.
module encoder_8to3
  import encoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [IN_W-1:0]  i,
  output logic [OUT_W-1:0] y,
  output logic             valid,
  output logic             multi
);

  logic [IN_W-1:0]  w_gated;
  logic [OUT_W-1:0] w_idx;
  logic             w_nz;
  logic             w_multi;

  logic [OUT_W-1:0] r_y;
  logic             r_valid;
  logic             r_multi;

  // Gate before the priority logic so an unknown request vector cannot reach the flops while disabled.
  assign w_gated = i & {IN_W{en}};

  encoder_8to3_core u_core (
    .i_vec   (w_gated),
    .o_idx   (w_idx),
    .o_nz    (w_nz),
    .o_multi (w_multi)
  );

  // Output registers: cleared asynchronously on reset, otherwise capture the encode result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y     <= IDX_RST;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
    end else begin
      r_y     <= w_idx;
      r_valid <= w_nz;
      r_multi <= w_multi;
    end
  end

  assign y     = r_y;
  assign valid = r_valid;
  assign multi = r_multi;

endmodule

// File: tb/tb_encoder_8to3.sv
// Self-checking bench for encoder_8to3: directed cases plus random vectors against a reference model.
// Latency: expects results one rising edge after inputs are applied.
// Backpressure: none exercised; the DUT has no handshake.
module tb_encoder_8to3;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] i;
  logic [2:0] y;
  logic       valid;
  logic       multi;

  int n_vec;
  int n_bad;

  encoder_8to3 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .i     (i),
    .y     (y),
    .valid (valid),
    .multi (multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: index = floor(log2(v)), valid = any request, multi = popcount >= 2.
  function automatic void model(input logic e, input logic [7:0] v,
                                output logic [2:0] ey, output logic ev, output logic em);
    int n;
    int val;
    ey = 3'd0;
    ev = 1'b0;
    em = 1'b0;
    if (e === 1'b1 && v != 8'd0) begin
      val = int'(v);
      n = 0;
      while ((1 << (n + 1)) <= val) n++;
      ey = 3'(n);
      ev = 1'b1;
      em = ($countones(v) >= 2);
    end
  endfunction

  task automatic check_out(input string tag, input logic [2:0] ey, input logic ev, input logic em);
    chk({tag, ".y"},     {5'd0, y},     {5'd0, ey});
    chk({tag, ".valid"}, {7'd0, valid}, {7'd0, ev});
    chk({tag, ".multi"}, {7'd0, multi}, {7'd0, em});
  endtask

  // Drive at the falling edge, let one rising edge sample, check shortly after it.
  task automatic apply(input string tag, input logic e, input logic [7:0] v);
    logic [2:0] ey;
    logic ev, em;
    @(negedge clk);
    en = e;
    i  = v;
    @(posedge clk);
    #1;
    model(e, v, ey, ev, em);
    check_out(tag, ey, ev, em);
  endtask

  initial begin
    logic [7:0] onehot;
    logic [7:0] rv;
    logic       re;
    n_vec = 0;
    n_bad = 0;

    // Reset held with a full request vector: outputs stay cleared.
    rst_n = 1'b0;
    en    = 1'b1;
    i     = 8'hFF;
    #1;
    check_out("rst_async", 3'd0, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_out("rst_hold", 3'd0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("rst_release", 3'd7, 1'b1, 1'b1);

    // One-hot sweep from bit 7 down to bit 1.
    for (int b = 7; b >= 1; b--) begin
      onehot = 8'd1 << b;
      apply("onehot", 1'b1, onehot);
    end

    // Zero versus a genuine bit-0 request.
    apply("zero", 1'b1, 8'h00);
    apply("bit0", 1'b1, 8'h01);

    // Multiple requests.
    apply("multi_2d", 1'b1, 8'b0010_1101);
    apply("multi_ff", 1'b1, 8'hFF);
    apply("multi_a1", 1'b1, 8'b1010_0001);
    apply("pair_low", 1'b1, 8'b0000_0011);

    // Disabled with unknown request bits.
    apply("dis_x", 1'b0, 8'bxxxx_xxxx);
    apply("dis_ff", 1'b0, 8'hFF);

    // Asynchronous reset pulse between edges while y = 6.
    apply("pre_rst", 1'b1, 8'h40);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("mid_rst", 3'd0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("post_rst", 3'd6, 1'b1, 1'b0);

    // Random vectors, mostly enabled.
    for (int k = 0; k < 200; k++) begin
      re = ($urandom_range(0, 9) != 0);
      rv = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rv = rv & 8'($urandom);
      apply("rand", re, rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/encoder_8to3.md
# encoder_8to3

Registered 8-to-3 priority encoder with enable. Each cycle it samples an 8-bit request vector and emits the index of the highest-numbered asserted bit, plus a valid flag and a multiple-request flag. It sits between request sources (interrupt lines, arbiter requests) and downstream logic that needs a compact binary index.

## Interface

- Parameters: none; widths are fixed at 8 inputs and 3 output bits.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `en` input 1: encode enable; when low the request vector is ignored.
- `i` input 8: request vector; bit 7 has highest priority.
- `y` output 3: registered index of the highest set bit of `i`.
- `valid` output 1: registered; high when `en` was high and `i` was nonzero.
- `multi` output 1: registered; high when `en` was high and two or more bits of `i` were set.

## Operation

- Priority: `y` equals the index n of the highest set bit of `i`.
  - Bit 7 wins over all others, bit 0 loses to all others.
  - Examples: `i`=8'b1000_0000 gives 7; 8'b0100_0000 gives 6; 8'b0000_0010 gives 1; 8'b1010_0001 gives 7.
- All-zero request (`en`=1, `i`=0): `y`=0, `valid`=0, `multi`=0.
  - `y`=0 with `valid`=0 is distinguishable from a real bit-0 request, which gives `y`=0 with `valid`=1.
- Disabled (`en`=0): `y`=0, `valid`=0, `multi`=0, whatever the value of `i`.
  - Applies even when `i` contains X or Z bits.
  - The combinational path must gate `i` with `en` before the priority logic, so X on `i` cannot reach the registers while `en`=0.
- Lower-priority bits below the winning bit never affect `y`; they only affect `multi`.
- No internal state other than the three output registers. There is no state machine.

## Timing

- Latency: one cycle. Inputs sampled on rising edge k appear on `y`, `valid` and `multi` immediately after edge k.
- Throughput: one new encode result per cycle; no handshake and no backpressure.
- Reset:
  - Asserting `rst_n` low immediately (asynchronously) forces `y`=3'b000, `valid`=0, `multi`=0.
  - Outputs hold those values while `rst_n` is low.
  - The first sample is taken at the first rising edge after `rst_n` deasserts.
- Reset mid-stream: any result pending at the time of reset is discarded; there is no recovery of prior state.
- Changes to `en` and `i` on the same edge are sampled together; `en` is not registered separately.

## Structure

- Sub-module `encoder_8to3_core`: purely combinational.
  - Inputs: gated 8-bit vector.
  - Outputs: 3-bit index, nonzero flag, multi flag.
  - Written as an explicit highest-bit-first priority chain (casez or descending loop), with no latches.
- Top `encoder_8to3`:
  - gates `i` with `en`;
  - instantiates the core;
  - holds the three output flops with async active-low reset.
- Shared package `encoder_pkg`: `IN_W`=8, `OUT_W`=3, and the reset value of the index, `IDX_RST`=3'b000.

## Test plan

- Reset: hold `rst_n`=0 with `en`=1 and `i`=8'hFF. Outputs stay 0/0/0. Release reset, then after one edge `y`=7, `valid`=1, `multi`=1.
- One-hot sweep: `en`=1, drive `i`=128, 64, 32, 16, 8, 4, 2 on successive cycles. The next cycle shows `y`=7, 6, 5, 4, 3, 2, 1 in turn, each with `valid`=1 and `multi`=0.
- Zero vs bit 0:
  - `i`=0 gives `y`=0, `valid`=0.
  - `i`=1 gives `y`=0, `valid`=1.
- Priority with multiple requests:
  - `i`=8'b0010_1101 gives `y`=5, `multi`=1.
  - `i`=8'b1111_1111 gives `y`=7, `multi`=1.
- Disable with X: `en`=0 and `i`=8'bx. The next cycle shows `y`=0, `valid`=0, `multi`=0, with no X on any output.
- Async reset mid-stream: pulse `rst_n` low between clock edges while `y`=6. Outputs drop to 0 before the next edge and resume correct encoding one edge after release.
